// File: rtl/mul_div_unit.sv
// mul_div_unit -- multi-cycle multiply/divide unit with architectural HI/LO.
//
// Sits beside the ALU in EX. Accepts mult/multu/div/divu/mthi/mtlo, models
// fixed latencies and raises busy so hazard logic can stall mfhi/mflo and
// further MDU ops. Requests arriving while busy are dropped.
//
// Optional feature: define MDU_MADD_EN to add madd/maddu/msub/msubu
// (ops 6..9, MUL_CYCLES latency, {hi,lo} accumulate with 2*WIDTH wrap).
// Without the macro those codes are reserved no-ops.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request strobe; op/operands sampled when high
//   mdu_op   in   [3:0] 0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo
//   op_a     in   [WIDTH-1:0] rs operand
//   op_b     in   [WIDTH-1:0] rt operand
//   busy     out  registered, high while a mul/div is in flight
//   hi       out  [WIDTH-1:0] HI register
//   lo       out  [WIDTH-1:0] LO register
module mul_div_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // ------------------------------------------------------------------
    // Datapath: one multiplier and one divider, shared by signed/unsigned
    // forms and evaluated from the latched operands at the commit edge.
    // ------------------------------------------------------------------
    logic                 mul_signed;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic                 a_neg, b_neg, div_signed;
    logic [WIDTH-1:0]     dvd, dvs, dvs_safe, q_mag, r_mag;
    logic [2*WIDTH-1:0]   res;

    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        // Low 2*WIDTH bits of the extended product are the exact result.
        prod  = a_ext * b_ext;

        // Signed divide runs on magnitudes; -2^(W-1) negates to itself,
        // which read unsigned is the correct magnitude, so MIN/-1 falls out.
        div_signed = (op_q == OP_DIV);
        a_neg    = div_signed & a_q[WIDTH-1];
        b_neg    = div_signed & b_q[WIDTH-1];
        dvd      = a_neg ? -a_q : a_q;
        dvs      = b_neg ? -b_q : b_q;
        dvs_safe = (dvs == '0) ? WIDTH'(1) : dvs;
        q_mag    = dvd / dvs_safe;
        r_mag    = dvd % dvs_safe;

        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    res = {a_q, {WIDTH{1'b1}}};
                end else begin
                    res[WIDTH-1:0]       = (a_neg ^ b_neg) ? -q_mag : q_mag;
                    res[2*WIDTH-1:WIDTH] = a_neg ? -r_mag : r_mag;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: res = {hi_q, lo_q} - prod;
`endif
            default: res = {hi_q, lo_q};
        endcase
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU,
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
`endif
                        OP_DIV, OP_DIVU: begin
                            op_d    = mdu_op_e'(mdu_op);
                            a_d     = op_a;
                            b_d     = op_b;
                            cnt_d   = ((mdu_op == OP_DIV) || (mdu_op == OP_DIVU)) ? DIV_LOAD : MUL_LOAD;
                            busy_d  = 1'b1;
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res[2*WIDTH-1:WIDTH];
                    lo_d    = res[WIDTH-1:0];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] op_a, op_b;
    logic        busy;
    logic [31:0] hi, lo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
    } vec_t;

    vec_t vecs[$];

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mdu_op(mdu_op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input int unsigned lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = h; v.lo = l; v.lat = lat;
        return v;
    endfunction

    // Issue one request and follow it to completion at its fixed latency.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        start = 1'b1; mdu_op = v.op; op_a = v.a; op_b = v.b;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int unsigned k = 0; k < v.lat; k++) begin
            check($sformatf("v%0d busy c%0d", idx, k), {31'b0, busy}, 32'd1);
            check($sformatf("v%0d hi hold c%0d", idx, k), hi, m_hi);
            check($sformatf("v%0d lo hold c%0d", idx, k), lo, m_lo);
            @(posedge clk); #1;
        end
        check($sformatf("v%0d busy done", idx), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d hi", idx), hi, v.hi);
        check($sformatf("v%0d lo", idx), lo, v.lo);
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mdu_op = '0; op_a = '0; op_b = '0;

        vecs.push_back(mk(4'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5));
        vecs.push_back(mk(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5));
        vecs.push_back(mk(4'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10));
        vecs.push_back(mk(4'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 10));
        vecs.push_back(mk(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10));
        vecs.push_back(mk(4'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10));
        vecs.push_back(mk(4'd3, 32'd100,       32'd7,        32'd2,         32'd14,        10));
        vecs.push_back(mk(4'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5));
        vecs.push_back(mk(4'd4, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFEB, 0));
        vecs.push_back(mk(4'd5, 32'hCAFE_BABE, 32'd0,        32'h1234_5678, 32'hCAFE_BABE, 0));
        vecs.push_back(mk(4'd15, 32'd1,        32'd1,        32'h1234_5678, 32'hCAFE_BABE, 0));
        vecs.push_back(mk(4'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         5));
        vecs.push_back(mk(4'd2, 32'h8000_0000, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF, 10));
`ifdef MDU_MADD_EN
        vecs.push_back(mk(4'd4, 32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF, 0));
        vecs.push_back(mk(4'd5, 32'hFFFF_FFFF, 32'd0,        32'd0,         32'hFFFF_FFFF, 0));
        vecs.push_back(mk(4'd7, 32'd1,         32'd1,        32'd1,         32'd0,         5));
        vecs.push_back(mk(4'd6, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 5));
        vecs.push_back(mk(4'd8, 32'hFFFF_FFFF, 32'd1,        32'd1,         32'd0,         5));
`else
        vecs.push_back(mk(4'd6, 32'd5,         32'd5,        32'h8000_0000, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(4'd9, 32'd5,         32'd5,        32'h8000_0000, 32'hFFFF_FFFF, 0));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Requests issued while busy (mthi, then another mult) are dropped.
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd0; op_a = 32'd2; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign busy c0", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd4; op_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign mthi busy", {31'b0, busy}, 32'd1);
        check("ign mthi hi", hi, m_hi);
        check("ign mthi lo", lo, m_lo);
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd0; op_a = 32'd100; op_b = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign mult busy", {31'b0, busy}, 32'd1);
        check("ign mult hi", hi, m_hi);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("ign busy tail%0d", k), {31'b0, busy}, 32'd1);
            check($sformatf("ign lo tail%0d", k), lo, m_lo);
        end
        @(posedge clk); #1;
        check("ign done busy", {31'b0, busy}, 32'd0);
        check("ign done hi", hi, 32'd0);
        check("ign done lo", lo, 32'd6);
        @(posedge clk); #1;
        check("ign no requeue busy", {31'b0, busy}, 32'd0);
        check("ign no requeue lo", lo, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;

        // Asynchronous reset in the middle of a divide.
        run_vec(100, mk(4'd4, 32'hAAAA_5555, 32'd0, 32'hAAAA_5555, 32'd6, 0));
        run_vec(101, mk(4'd5, 32'h5555_AAAA, 32'd0, 32'hAAAA_5555, 32'h5555_AAAA, 0));
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd2; op_a = 32'd100; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst pre busy", {31'b0, busy}, 32'd1);
        check("rst pre hi", hi, 32'hAAAA_5555);
        reset_n = 1'b0;
        #1;
        check("rst async busy", {31'b0, busy}, 32'd0);
        check("rst async hi", hi, 32'd0);
        check("rst async lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst post busy%0d", k), {31'b0, busy}, 32'd0);
            check($sformatf("rst post hi%0d", k), hi, 32'd0);
            check($sformatf("rst post lo%0d", k), lo, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage. Accepts mult/multu/div/divu/mthi/mtlo, models fixed MIPS-style latencies, and exposes busy so hazard logic can stall mfhi/mflo and further MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, multiply latency in cycles (>=1).
- DIV_CYCLES, 10, divide latency in cycles (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; op/operands sampled on the rising edge when start=1.
- mdu_op  in  4  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; others reserved, treated as no-op.
- op_a  in  WIDTH  rs operand.
- op_b  in  WIDTH  rt operand.
- busy  out  1  registered; high while a mul/div is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. reset_n=0 forces busy=0, hi=0, lo=0, counter=0, state=IDLE immediately, including mid-operation. The in-flight result is discarded.
- FSM states:
  - IDLE: start=1 with op 0/1 latches op_a, op_b and op, loads counter=MUL_CYCLES, goes to BUSY. Op 2/3 does the same with counter=DIV_CYCLES.
  - BUSY: counter decrements each edge. On the edge where counter==1, hi/lo are written, busy drops, and the FSM returns to IDLE.
- busy timing: busy is high for exactly N cycles after the start edge (N = MUL_CYCLES or DIV_CYCLES). hi/lo are first valid in the cycle busy reads 0 again.
- mthi/mtlo (op 4/5) in IDLE: hi<=op_a (or lo<=op_a) on that edge, 1-cycle effect, busy stays 0.
- start while busy=1: ignored entirely, whatever the op. hi/lo are not touched; the controller must stall.
- Reserved op with start=1: no state change.
- mult: signed WIDTH x WIDTH -> 2*WIDTH; hi=upper half, lo=lower half.
- multu: the same, unsigned.
- div: signed; quotient truncates toward zero (lo), remainder takes the sign of the dividend (hi). The -2^(WIDTH-1) / -1 case gives lo=-2^(WIDTH-1), hi=0 (no trap).
- divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero: lo=all ones, hi=op_a (as latched). No exception; latency unchanged.
- Operands are latched at start, so op_a/op_b changes during BUSY have no effect.
- hi/lo hold their old values throughout BUSY. The result commits atomically.
- start=1 in the cycle busy falls (FSM already IDLE): accepted as a new operation. Back-to-back issue has no bubble beyond the busy period.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, adds mdu_op 6=madd, 7=maddu, 8=msub, 9=msubu. These are MUL_CYCLES latency. {hi,lo} <= {hi,lo} +/- product (signed for madd/msub, unsigned for the u forms), 2*WIDTH wrap-around, with {hi,lo} read at the commit edge.
- When undefined, codes 6-9 are reserved no-ops and no accumulate adder is synthesised.

Test Plan:
- Reset, then mult op_a=0xFFFFFFFE (-2), op_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div op_a=-7 (0xFFFFFFF9), op_b=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/0 -> lo=0xFFFFFFFF, hi=7.
- mthi 0x12345678 then a start of mult issued during busy:
  - mthi -> hi updates the next edge, busy stays 0.
  - mult during busy -> ignored; hi/lo unchanged by the ignored request.
- Start div, drive reset_n=0 asynchronously mid-BUSY (cycle 4) -> busy, hi, lo become 0 without a clock edge. After release, idle with no late commit.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu 1x1 -> hi=1, lo=0.
